// File: rtl/ysyx_23060332_mem_arbiter.sv
// ysyx_23060332_mem_arbiter
// Shares the single data-memory port between the IFU (read-only fetch) and
// the LSU (loads/stores). One transaction at a time walks IDLE -> REQ ->
// WAIT -> RESP. Requesters are picked round-robin. A response timeout turns
// a hung memory into an error response.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   ifu_valid/addr             IFU read request
//   ifu_ready                  IFU request accepted (combinational, IDLE only)
//   ifu_rvalid/rdata/err       one-cycle IFU response
//   lsu_valid/wen/addr/wdata/wmask   LSU request
//   lsu_ready                  LSU request accepted (combinational, IDLE only)
//   lsu_rvalid/rdata/err       one-cycle LSU response (rdata is 0 for writes)
//   m_valid/ready/wen/addr/wdata/wmask   downstream request channel
//   m_rvalid/rdata             downstream response channel
module ysyx_23060332_mem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MASK_W  = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_valid,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_ready,
    output logic              ifu_rvalid,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic              ifu_err,
    input  logic              lsu_valid,
    input  logic              lsu_wen,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [MASK_W-1:0] lsu_wmask,
    output logic              lsu_ready,
    output logic              lsu_rvalid,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_err,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_wen,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [MASK_W-1:0] m_wmask,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata
);

    // Counter must hold the value TIMEOUT itself; keep one bit when disabled.
    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_t;

    typedef enum logic {
        SRC_IFU,
        SRC_LSU
    } src_t;

    typedef struct packed {
        logic              wen;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [MASK_W-1:0] wmask;
    } req_t;

    state_t           state;
    src_t             owner;
    src_t             last_grant;
    req_t             pend_req;
    logic [CNT_W-1:0] cnt;

    logic              grant_ifu;
    logic              grant_lsu;
    logic              resp_timeout;
    logic [DATA_W-1:0] resp_data;

    // Round-robin pick; only offered in IDLE and never while reset is held.
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (!rst && state == S_IDLE) begin
            if (ifu_valid && lsu_valid) begin
                grant_ifu = (last_grant == SRC_LSU);
                grant_lsu = (last_grant == SRC_IFU);
            end else begin
                grant_ifu = ifu_valid;
                grant_lsu = lsu_valid;
            end
        end
    end

    assign ifu_ready = grant_ifu;
    assign lsu_ready = grant_lsu;

    // A real response in the same cycle as the limit wins over the timeout.
    always_comb begin
        resp_timeout = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT)) && !m_rvalid;
        resp_data    = (m_rvalid && !pend_req.wen) ? m_rdata : '0;
    end

    assign m_wen   = pend_req.wen;
    assign m_addr  = pend_req.addr;
    assign m_wdata = pend_req.wdata;
    assign m_wmask = pend_req.wmask;

    // Transaction sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            owner      <= SRC_IFU;
            last_grant <= SRC_IFU;
            pend_req   <= '0;
            cnt        <= '0;
            m_valid    <= 1'b0;
            ifu_rvalid <= 1'b0;
            ifu_rdata  <= '0;
            ifu_err    <= 1'b0;
            lsu_rvalid <= 1'b0;
            lsu_rdata  <= '0;
            lsu_err    <= 1'b0;
        end else begin
            // Response strobes live for a single cycle.
            ifu_rvalid <= 1'b0;
            ifu_rdata  <= '0;
            ifu_err    <= 1'b0;
            lsu_rvalid <= 1'b0;
            lsu_rdata  <= '0;
            lsu_err    <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (grant_ifu) begin
                        pend_req.wen   <= 1'b0;
                        pend_req.addr  <= ifu_addr;
                        pend_req.wdata <= '0;
                        pend_req.wmask <= '0;
                        owner          <= SRC_IFU;
                        last_grant     <= SRC_IFU;
                        m_valid        <= 1'b1;
                        state          <= S_REQ;
                    end else if (grant_lsu) begin
                        pend_req.wen   <= lsu_wen;
                        pend_req.addr  <= lsu_addr;
                        pend_req.wdata <= lsu_wdata;
                        pend_req.wmask <= lsu_wmask;
                        owner          <= SRC_LSU;
                        last_grant     <= SRC_LSU;
                        m_valid        <= 1'b1;
                        state          <= S_REQ;
                    end
                end

                S_REQ: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        cnt     <= '0;
                        state   <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (m_rvalid || resp_timeout) begin
                        state <= S_RESP;
                        if (owner == SRC_IFU) begin
                            ifu_rvalid <= 1'b1;
                            ifu_rdata  <= resp_data;
                            ifu_err    <= resp_timeout;
                        end else begin
                            lsu_rvalid <= 1'b1;
                            lsu_rdata  <= resp_data;
                            lsu_err    <= resp_timeout;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_RESP: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060332_mem_arbiter.sv
// Self-checking bench for ysyx_23060332_mem_arbiter.
// The bench plays both requesters and the memory. Each transaction's
// expected timeline (grant, request window, response cycle, data, error)
// is computed from the round-robin rule and the latency arithmetic.
module tb_ysyx_23060332_mem_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_valid;
    logic [31:0] ifu_addr;
    logic        ifu_ready;
    logic        ifu_rvalid;
    logic [31:0] ifu_rdata;
    logic        ifu_err;
    logic        lsu_valid;
    logic        lsu_wen;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [7:0]  lsu_wmask;
    logic        lsu_ready;
    logic        lsu_rvalid;
    logic [31:0] lsu_rdata;
    logic        lsu_err;
    logic        m_valid;
    logic        m_ready;
    logic        m_wen;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [7:0]  m_wmask;
    logic        m_rvalid;
    logic [31:0] m_rdata;

    logic [143:0] all_out;
    assign all_out = {ifu_ready, ifu_rvalid, ifu_rdata, ifu_err,
                      lsu_ready, lsu_rvalid, lsu_rdata, lsu_err,
                      m_valid, m_wen, m_addr, m_wdata, m_wmask};

    int n_checks = 0;
    int n_err    = 0;

    // Requester-side model: pending requests and who was served last.
    bit          ifu_pend = 1'b0;
    logic [31:0] ifu_a    = '0;
    bit          lsu_pend = 1'b0;
    bit          lsu_w    = 1'b0;
    logic [31:0] lsu_a    = '0;
    logic [31:0] lsu_d    = '0;
    logic [7:0]  lsu_m    = '0;
    bit          last_lsu = 1'b0;

    bit w1, w2, w3, wd;

    ysyx_23060332_mem_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .MASK_W (8),
        .TIMEOUT(TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ifu_valid (ifu_valid),
        .ifu_addr  (ifu_addr),
        .ifu_ready (ifu_ready),
        .ifu_rvalid(ifu_rvalid),
        .ifu_rdata (ifu_rdata),
        .ifu_err   (ifu_err),
        .lsu_valid (lsu_valid),
        .lsu_wen   (lsu_wen),
        .lsu_addr  (lsu_addr),
        .lsu_wdata (lsu_wdata),
        .lsu_wmask (lsu_wmask),
        .lsu_ready (lsu_ready),
        .lsu_rvalid(lsu_rvalid),
        .lsu_rdata (lsu_rdata),
        .lsu_err   (lsu_err),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_wen     (m_wen),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_wmask   (m_wmask),
        .m_rvalid  (m_rvalid),
        .m_rdata   (m_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_lsu(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [7:0] m);
        lsu_pend = 1'b1;
        lsu_w    = w;
        lsu_a    = a;
        lsu_d    = d;
        lsu_m    = m;
    endtask

    // Random requesters: may withdraw a pending request, may raise a new one.
    task automatic gen_requests();
        if (ifu_pend && $urandom_range(0, 4) == 0) ifu_pend = 1'b0;
        if (lsu_pend && $urandom_range(0, 4) == 0) lsu_pend = 1'b0;
        if (!ifu_pend && $urandom_range(0, 1) == 1) begin
            ifu_pend = 1'b1;
            ifu_a    = $urandom;
        end
        if (!lsu_pend && $urandom_range(0, 1) == 1)
            set_lsu(1'(($urandom_range(0, 1))), $urandom, $urandom, 8'($urandom));
        if (!ifu_pend && !lsu_pend) begin
            ifu_pend = 1'b1;
            ifu_a    = $urandom;
        end
    endtask

    // One transaction starting at an IDLE cycle (called at posedge+1).
    // fd1: cycles m_ready is held low in REQ; fd2: WAIT cycles before m_rvalid
    // (values above TO mean the memory is late and a timeout is expected).
    task automatic do_txn(input int fd1, input int fd2, input bit frd_en,
                          input logic [31:0] frd, output bit won_lsu);
        int          d1;
        int          d2;
        int          t_resp;
        bit          to;
        bit          w_lsu;
        logic [31:0] rd;
        logic [72:0] exp_req;
        logic [31:0] exp_data;

        w_lsu    = (ifu_pend && lsu_pend) ? !last_lsu : lsu_pend;
        last_lsu = w_lsu;
        exp_req  = w_lsu ? {lsu_w, lsu_a, lsu_d, lsu_m} : {1'b0, ifu_a, 32'h0, 8'h0};
        d1       = (fd1 >= 0) ? fd1 : int'($urandom_range(0, 3));
        d2       = (fd2 >= 0) ? fd2 : int'($urandom_range(0, TO + 1));
        rd       = frd_en ? frd : $urandom;
        to       = (d2 > TO);
        t_resp   = to ? (3 + d1 + TO) : (3 + d1 + d2);
        exp_data = (to || (w_lsu && lsu_w)) ? 32'h0 : rd;
        won_lsu  = 1'b0;

        ifu_valid = ifu_pend;
        ifu_addr  = ifu_a;
        lsu_valid = lsu_pend;
        lsu_wen   = lsu_w;
        lsu_addr  = lsu_a;
        lsu_wdata = lsu_d;
        lsu_wmask = lsu_m;
        m_ready   = 1'b0;
        m_rvalid  = 1'b0;
        m_rdata   = $urandom;
        if (w_lsu) lsu_pend = 1'b0;
        else       ifu_pend = 1'b0;

        for (int t = 0; t <= t_resp; t++) begin
            if (t > 0) begin
                ifu_valid = ifu_pend;
                lsu_valid = lsu_pend;
                m_ready   = (t == 1 + d1) || (t > 1 + d1 && $urandom_range(0, 1) == 1);
                m_rvalid  = (t == 2 + d1 + d2) || (t <= 1 + d1 && $urandom_range(0, 1) == 1);
                m_rdata   = (t == 2 + d1 + d2) ? rd : $urandom;
            end
            @(negedge clk);
            check_eq("ready", {ifu_ready, lsu_ready}, (t == 0) ? {!w_lsu, w_lsu} : 2'b00);
            if (t >= 1 && t <= 1 + d1)
                check_eq("m_req", {m_valid, m_wen, m_addr, m_wdata, m_wmask}, {1'b1, exp_req});
            else
                check_eq("m_valid_low", 160'(m_valid), 160'(0));
            check_eq("rvalid", {ifu_rvalid, lsu_rvalid}, (t == t_resp) ? {!w_lsu, w_lsu} : 2'b00);
            if (t == t_resp)
                check_eq("resp", w_lsu ? {lsu_err, lsu_rdata} : {ifu_err, ifu_rdata}, {to, exp_data});
            if (t == 0) won_lsu = lsu_ready;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        ifu_valid = 1'b0;
        ifu_addr  = '0;
        lsu_valid = 1'b0;
        lsu_wen   = 1'b0;
        lsu_addr  = '0;
        lsu_wdata = '0;
        lsu_wmask = '0;
        m_ready   = 1'b0;
        m_rvalid  = 1'b0;
        m_rdata   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset_outputs", 160'(all_out), 160'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Both requesters held high: LSU, IFU, LSU.
        ifu_pend = 1'b1;
        ifu_a    = 32'h8000_0100;
        set_lsu(1'b0, 32'h8000_2000, 32'h0, 8'h0);
        do_txn(0, 0, 1'b0, 32'h0, w1);
        set_lsu(1'b1, 32'h8000_2004, 32'h1111_2222, 8'hF0);
        do_txn(0, 1, 1'b0, 32'h0, w2);
        ifu_pend = 1'b1;
        ifu_a    = 32'h8000_0104;
        do_txn(1, 0, 1'b0, 32'h0, w3);
        check_eq("contention_order", {w1, w2, w3}, 3'b101);

        // IFU-only read.
        ifu_pend = 1'b1;
        ifu_a    = 32'h8000_0000;
        do_txn(0, 0, 1'b1, 32'h0000_0413, wd);

        // LSU write: response data must be 0 even if memory returns junk.
        set_lsu(1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 8'h0F);
        do_txn(0, 0, 1'b1, 32'h1234_5678, wd);

        // Backpressure: m_ready low for 5 cycles in REQ.
        set_lsu(1'b0, 32'h8000_3000, 32'h0, 8'h0);
        do_txn(5, 1, 1'b0, 32'h0, wd);

        // Response on the very cycle the counter reaches the limit wins.
        ifu_pend = 1'b1;
        ifu_a    = 32'h8000_0200;
        do_txn(0, TO, 1'b0, 32'h0, wd);

        // Timeout with a late m_rvalid landing in the response cycle.
        ifu_pend = 1'b1;
        ifu_a    = 32'h8000_0300;
        do_txn(0, TO + 1, 1'b0, 32'h0, wd);

        repeat (200) begin
            gen_requests();
            do_txn(-1, -1, 1'b0, 32'h0, wd);
        end

        // Reset pulsed in WAIT.
        ifu_pend  = 1'b0;
        lsu_pend  = 1'b0;
        ifu_valid = 1'b1;
        ifu_addr  = 32'h8000_0400;
        lsu_valid = 1'b0;
        m_ready   = 1'b0;
        m_rvalid  = 1'b0;
        @(negedge clk);
        check_eq("rst_accept", {ifu_ready, lsu_ready}, 2'b10);
        @(posedge clk);
        #1;
        ifu_valid = 1'b0;
        m_ready   = 1'b1;
        @(negedge clk);
        check_eq("rst_req", 160'(m_valid), 160'(1));
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        m_rvalid = 1'b1;
        m_rdata  = 32'hCAFE_F00D;
        @(negedge clk);
        check_eq("rst_outputs", 160'(all_out), 160'(0));
        @(posedge clk);
        #1;
        m_rvalid = 1'b0;
        @(negedge clk);
        check_eq("rst_no_rvalid", 160'(all_out), 160'(0));
        @(posedge clk);
        #1;

        // Normal service after reset; round-robin history is cleared too.
        last_lsu = 1'b0;
        ifu_pend = 1'b1;
        ifu_a    = 32'h8000_0500;
        do_txn(0, 0, 1'b0, 32'h0, wd);
        ifu_pend = 1'b1;
        ifu_a    = 32'h8000_0504;
        set_lsu(1'b0, 32'h8000_5000, 32'h0, 8'h0);
        do_txn(-1, -1, 1'b0, 32'h0, w1);
        check_eq("post_reset_rr", 160'(w1), 160'(1));
        do_txn(-1, -1, 1'b0, 32'h0, wd);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
